// File: rtl/reg_bank.sv
// Register bank with DEPTH entries of WIDTH bits. It has separate write and read addresses,
// an in-place increment mode, and a registered read port with write-through bypass.
module reg_bank #(
    parameter int unsigned          WIDTH     = 8,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    localparam int unsigned         AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             inc_n,
    input  logic             enable_n,
    input  logic [AW-1:0]    wr_addr,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] reg_in,
    output logic [WIDTH-1:0] reg_out,
    output logic             out_valid,
    output logic             carry
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] entry [DEPTH];

    logic             wr_ok;
    logic             rd_ok;
    logic             wr_act;
    logic             carry_next;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH-1:0] rd_value;

    // When DEPTH is not a power of two, some address codes have no entry behind them.
    assign wr_ok = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_W);

    always_comb begin
        old_val    = '0;
        new_val    = '0;
        wr_act     = 1'b0;
        carry_next = 1'b0;
        rd_value   = '0;

        if (wr_ok) begin
            old_val = entry[wr_addr];
        end

        if (!load_n) begin
            new_val = reg_in;
            wr_act  = wr_ok;
        end else if (!inc_n) begin
            new_val    = old_val + WIDTH'(1);
            wr_act     = wr_ok;
            carry_next = wr_ok && (old_val == '1);
        end

        // A read of the entry being written returns the value it is about to hold.
        if (rd_ok) begin
            if (wr_act && (rd_addr == wr_addr)) begin
                rd_value = new_val;
            end else begin
                rd_value = entry[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry[i] <= RESET_VAL;
            end
            reg_out   <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
        end else begin
            if (wr_act) begin
                entry[wr_addr] <= new_val;
            end
            carry <= carry_next;
            if (!enable_n) begin
                reg_out   <= rd_value;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
